// File: rtl/plru_replacer.sv
// Tree pseudo-LRU replacement unit. One (WAYS-1)-bit heap-ordered tree per
// set; on a hit the given way is promoted, on a miss a victim is chosen
// (first invalid way, else the tree walk) and promoted. Answer returned
// through a single registered valid/ready response stage.
module plru_replacer #(
  parameter  int WAYS = 8,
  parameter  int SETS = 16,
  localparam int WB   = $clog2(WAYS),
  localparam int SB   = $clog2(SETS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [SB-1:0]   req_set_i,
  input  logic            req_hit_i,
  input  logic [WB-1:0]   req_way_i,
  input  logic [WAYS-1:0] req_vmask_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [WB-1:0]   resp_way_o,
  output logic            resp_hit_o,
  output logic            resp_fill_o
);

  logic [SETS-1:0][WAYS-2:0] tree_q;
  logic [WAYS-2:0]           tree_cur, tree_d;

  logic            resp_valid_q, resp_hit_q, resp_fill_q;
  logic [WB-1:0]   resp_way_q;

  logic [WB-1:0]   inv_way, walk_way, tgt_way;
  logic            has_inv, fill_d;
  logic [WB-1:0]   wnode, unode;
  logic            accept;

  // A new request may enter when the output slot is free or being drained;
  // clear owns the tree array for its cycle.
  assign req_ready_o = !clear_i && (!resp_valid_q || resp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  // Victim selection and path update, all from the current tree of the set.
  always_comb begin
    tree_cur = tree_q[req_set_i];

    // Lowest-index invalid way wins over the tree.
    inv_way = '0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (!req_vmask_i[i]) inv_way = WB'(i);
    end
    has_inv = ~&req_vmask_i;

    // Walk: node bit 0 -> lower half (left child), 1 -> upper half.
    // The node index after the last level is a leaf and is never used, so
    // truncation there is harmless.
    walk_way = '0;
    wnode    = '0;
    for (int l = 0; l < WB; l++) begin
      walk_way[WB-1-l] = tree_cur[wnode];
      wnode = (wnode << 1) + WB'(1) + WB'(tree_cur[wnode]);
    end

    fill_d  = !req_hit_i && has_inv;
    tgt_way = req_hit_i ? req_way_i : (has_inv ? inv_way : walk_way);

    // Point every node on the target's path away from the target.
    tree_d = tree_cur;
    unode  = '0;
    for (int l = 0; l < WB; l++) begin
      tree_d[unode] = ~tgt_way[WB-1-l];
      unode = (unode << 1) + WB'(1) + WB'(tgt_way[WB-1-l]);
    end
  end

  // Tree storage: clear wipes every set, accepted requests rewrite one set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tree_q <= '0;
    end else if (clear_i) begin
      tree_q <= '0;
    end else if (accept) begin
      tree_q[req_set_i] <= tree_d;
    end
  end

  // Response register: load on accept, drop on take, otherwise hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_way_q   <= '0;
      resp_hit_q   <= 1'b0;
      resp_fill_q  <= 1'b0;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      resp_way_q   <= tgt_way;
      resp_hit_q   <= req_hit_i;
      resp_fill_q  <= fill_d;
    end else if (resp_ready_i) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_way_o   = resp_way_q;
  assign resp_hit_o   = resp_hit_q;
  assign resp_fill_o  = resp_fill_q;

endmodule

// File: tb/tb_plru_replacer.sv
// Directed bench for plru_replacer (8 ways, 16 sets) with hand-derived
// victim sequences.
module tb_plru_replacer;

  localparam int WAYS = 8;
  localparam int SETS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_set;
  logic       req_hit;
  logic [2:0] req_way;
  logic [7:0] req_vmask;
  logic       resp_valid;
  logic       resp_ready;
  logic [2:0] resp_way;
  logic       resp_hit;
  logic       resp_fill;

  int checks   = 0;
  int failures = 0;

  plru_replacer #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_set_i    (req_set),
    .req_hit_i    (req_hit),
    .req_way_i    (req_way),
    .req_vmask_i  (req_vmask),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_way_o   (resp_way),
    .resp_hit_o   (resp_hit),
    .resp_fill_o  (resp_fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request (called #1 after a rising edge), let it be accepted
  // at the next edge, then check the registered response.
  task automatic do_req(input string tag, input logic [3:0] s, input logic h,
                        input logic [2:0] w, input logic [7:0] vm,
                        input logic [2:0] exp_way, input logic exp_fill);
    req_valid = 1'b1; req_set = s; req_hit = h; req_way = w; req_vmask = vm;
    #1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".resp_way"},   32'(resp_way),   32'(exp_way));
    chk({tag, ".resp_hit"},   32'(resp_hit),   32'(h));
    chk({tag, ".resp_fill"},  32'(resp_fill),  32'(exp_fill));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int seq8 [8];

  initial begin
    rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; req_set = '0; req_hit = 1'b0;
    req_way = '0; req_vmask = '1; resp_ready = 1'b1;
    #12;
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_way",   32'(resp_way),   32'd0);
    chk("rst.resp_hit",   32'(resp_hit),   32'd0);
    chk("rst.resp_fill",  32'(resp_fill),  32'd0);
    chk("rst.req_ready",  32'(req_ready),  32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Eight back-to-back full-set misses walk the tree through all ways.
    seq8 = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int i = 0; i < 8; i++)
      do_req($sformatf("seq%0d", i), 4'd2, 1'b0, 3'd0, 8'hFF, 3'(seq8[i]), 1'b0);
    @(posedge clk); #1;
    chk("seq.drain", 32'(resp_valid), 32'd0);

    // Hit promotes way 0; set isolation.
    do_reset();
    do_req("hit0",  4'd3, 1'b1, 3'd0, 8'hFF, 3'd0, 1'b0);
    do_req("s3mis", 4'd3, 1'b0, 3'd5, 8'hFF, 3'd4, 1'b0);
    do_req("s5mis", 4'd5, 1'b0, 3'd0, 8'hFF, 3'd0, 1'b0);

    // Invalid-way fill then tree victim.
    do_req("fill3", 4'd1, 1'b0, 3'd0, 8'hF7, 3'd3, 1'b1);
    do_req("aft3",  4'd1, 1'b0, 3'd0, 8'hFF, 3'd4, 1'b0);
    @(posedge clk); #1;
    chk("bp.idle", 32'(resp_valid), 32'd0);

    // Backpressure: response held stable, queued request waits.
    resp_ready = 1'b0;
    do_req("bp1", 4'd1, 1'b0, 3'd0, 8'hFF, 3'd0, 1'b0);
    req_valid = 1'b1; req_set = 4'd1; req_hit = 1'b0; req_vmask = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp.ready%0d", c), 32'(req_ready),  32'd0);
      chk($sformatf("bp.way%0d", c),   32'(resp_way),   32'd0);
      chk($sformatf("bp.vld%0d", c),   32'(resp_valid), 32'd1);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp2.vld", 32'(resp_valid), 32'd1);
    chk("bp2.way", 32'(resp_way),   32'd6);

    // Clear zeroes every tree and blocks acceptance that cycle.
    do_req("c0", 4'd0, 1'b0, 3'd0, 8'hFF, 3'd0, 1'b0);
    do_req("c1", 4'd0, 1'b0, 3'd0, 8'hFF, 3'd4, 1'b0);
    do_req("c2", 4'd0, 1'b0, 3'd0, 8'hFF, 3'd2, 1'b0);
    do_req("c3", 4'd0, 1'b0, 3'd0, 8'hFF, 3'd6, 1'b0);
    clear = 1'b1; req_valid = 1'b1; req_set = 4'd0; req_hit = 1'b0; req_vmask = 8'hFF;
    #1;
    chk("clr.req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; req_valid = 1'b0;
    chk("clr.no_accept", 32'(resp_valid), 32'd0);
    do_req("clr.after", 4'd0, 1'b0, 3'd0, 8'hFF, 3'd0, 1'b0);
    do_req("clr.next",  4'd0, 1'b0, 3'd0, 8'hFF, 3'd4, 1'b0);

    // Asynchronous reset drops a held response immediately.
    resp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.resp_valid", 32'(resp_valid), 32'd0);
    chk("arst.resp_way",   32'(resp_way),   32'd0);
    @(negedge clk); rst_n = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    do_req("arst.first", 4'd0, 1'b0, 3'd0, 8'hFF, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
